// File: rtl/imu_spi_sampler_if.sv
// Bus bundle for imu_spi_sampler: SPI pins towards the IMU plus the published
// sample word, its valid pulse and the busy flag.
interface imu_spi_sampler_if;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [95:0] data;
    logic        data_valid;
    logic        busy;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        output data,
        output data_valid,
        output busy
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        input  data,
        input  data_valid,
        input  busy
    );
endinterface

// File: rtl/imu_spi_sampler.sv
// SPI IMU sampler: one wake write after reset, then a 6-byte accel burst read every
// SAMPLE_PERIOD clocks, packed into a 96-bit word. Optional macro IMU_FILTER_EN adds a per-axis IIR.
module imu_spi_sampler #(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 300000,
    parameter logic [7:0] READ_ADDR     = 8'h3B,
    parameter logic [7:0] WAKE_ADDR     = 8'h6B,
    parameter logic [7:0] WAKE_VALUE    = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    imu_spi_sampler_if.master imu
);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    localparam logic [2:0] ST_WAKE    = 3'd0;
    localparam logic [2:0] ST_GAP     = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_HIGH  = 2'd2;

    logic [2:0]       state_r;
    logic [1:0]       phase_r;
    logic             active_r;
    logic [DIV_W-1:0] div_r;
    logic [5:0]       bit_r;
    logic [55:0]      tx_r;
    logic [47:0]      rx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             overrun_r;
    logic             sclk_r;
    logic             cs_n_r;
    logic             mosi_r;
    logic [95:0]      data_r;
    logic             valid_r;
    logic             busy_r;

    logic             tick_s;
    logic             div_done_s;
    logic             last_bit_s;
    logic [15:0]      raw_x_s;
    logic [15:0]      raw_y_s;
    logic [15:0]      raw_z_s;
    logic [15:0]      x_s;
    logic [15:0]      y_s;
    logic [15:0]      z_s;
    logic [95:0]      pack_s;

    assign tick_s     = (cnt_r == CNT_LAST);
    assign div_done_s = (div_r == DIV_LAST);
    assign last_bit_s = (state_r == ST_READ) ? (bit_r == 6'd55) : (bit_r == 6'd15);

    // Bytes arrive XH XL YH YL ZH ZL; the dummy byte clocked in during the address is shifted out
    assign raw_x_s = rx_r[47:32];
    assign raw_y_s = rx_r[31:16];
    assign raw_z_s = rx_r[15:0];

`ifdef IMU_FILTER_EN
    logic [15:0] filt_x_r;
    logic [15:0] filt_y_r;
    logic [15:0] filt_z_r;

    function automatic logic [15:0] iir_step(input logic [15:0] f, input logic [15:0] raw);
        logic signed [16:0] diff;
        diff = $signed({raw[15], raw}) - $signed({f[15], f});
        diff = diff >>> 2;
        return f + diff[15:0];
    endfunction

    assign x_s = iir_step(filt_x_r, raw_x_s);
    assign y_s = iir_step(filt_y_r, raw_y_s);
    assign z_s = iir_step(filt_z_r, raw_z_s);

    // Filter state advances only when a sample is published
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_x_r <= 16'h0000;
            filt_y_r <= 16'h0000;
            filt_z_r <= 16'h0000;
        end else if (state_r == ST_PUBLISH) begin
            filt_x_r <= x_s;
            filt_y_r <= y_s;
            filt_z_r <= z_s;
        end else begin
            filt_x_r <= filt_x_r;
            filt_y_r <= filt_y_r;
            filt_z_r <= filt_z_r;
        end
    end
`else
    assign x_s = raw_x_s;
    assign y_s = raw_y_s;
    assign z_s = raw_z_s;
`endif

    assign pack_s = {data_r[95:80] + 16'd1, 16'h0000, z_s, x_s, y_s, 15'h0000, overrun_r};

    // Sample-period counter, free-running from reset release
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= CNT_W'(0);
        end else if (tick_s) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sequencer and SPI bit engine; every pin and the published word are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_WAKE;
            phase_r   <= PH_SETUP;
            active_r  <= 1'b0;
            div_r     <= DIV_W'(0);
            bit_r     <= 6'd0;
            tx_r      <= 56'h0;
            rx_r      <= 48'h0;
            overrun_r <= 1'b0;
            sclk_r    <= 1'b1;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            data_r    <= 96'h0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_WAKE, ST_READ: begin
                    if (!active_r) begin
                        active_r <= 1'b1;
                        cs_n_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        phase_r  <= PH_SETUP;
                        div_r    <= DIV_W'(0);
                        bit_r    <= 6'd0;
                        tx_r     <= (state_r == ST_WAKE)
                                    ? {1'b0, WAKE_ADDR[6:0], WAKE_VALUE, 40'h0}
                                    : {1'b1, READ_ADDR[6:0], 48'h0};
                    end else if (div_done_s) begin
                        div_r <= DIV_W'(0);
                        case (phase_r)
                            PH_LOW: begin
                                sclk_r  <= 1'b1;
                                rx_r    <= {rx_r[46:0], imu.spi_miso};
                                phase_r <= PH_HIGH;
                            end
                            PH_HIGH: begin
                                if (last_bit_s) begin
                                    cs_n_r   <= 1'b1;
                                    active_r <= 1'b0;
                                    phase_r  <= PH_SETUP;
                                    if (state_r == ST_WAKE) begin
                                        state_r <= ST_GAP;
                                    end else begin
                                        state_r <= ST_PUBLISH;
                                        busy_r  <= 1'b0;
                                    end
                                end else begin
                                    bit_r   <= bit_r + 6'd1;
                                    sclk_r  <= 1'b0;
                                    mosi_r  <= tx_r[55];
                                    tx_r    <= {tx_r[54:0], 1'b0};
                                    phase_r <= PH_LOW;
                                end
                            end
                            default: begin
                                sclk_r  <= 1'b0;
                                mosi_r  <= tx_r[55];
                                tx_r    <= {tx_r[54:0], 1'b0};
                                phase_r <= PH_LOW;
                            end
                        endcase
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (div_r == GAP_LAST) begin
                        div_r   <= DIV_W'(0);
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (tick_s) begin
                        state_r <= ST_READ;
                    end
                end
                ST_PUBLISH: begin
                    data_r    <= pack_s;
                    valid_r   <= 1'b1;
                    // A tick dropped in this very cycle belongs to the next sample
                    overrun_r <= tick_s;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_WAKE;
                end
            endcase
        end
    end

    assign imu.spi_sclk   = sclk_r;
    assign imu.spi_cs_n   = cs_n_r;
    assign imu.spi_mosi   = mosi_r;
    assign imu.data       = data_r;
    assign imu.data_valid = valid_r;
    assign imu.busy       = busy_r;
endmodule

// File: tb/tb_imu_spi_sampler.sv
// Directed bench for imu_spi_sampler: one instance with a 2000-cycle period and a
// mode-3 slave model, one with a 50-cycle period to force dropped ticks.
module tb_imu_spi_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic rst_b;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    imu_spi_sampler_if ifa();
    imu_spi_sampler_if ifb();

    imu_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(2000), .READ_ADDR(8'h3B),
                      .WAKE_ADDR(8'h6B), .WAKE_VALUE(8'h00))
        dut_a (.clk(clk), .reset_n(reset_n), .imu(ifa));

    imu_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(50), .READ_ADDR(8'h3B),
                      .WAKE_ADDR(8'h6B), .WAKE_VALUE(8'h00))
        dut_b (.clk(clk), .reset_n(rst_b), .imu(ifb));

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model for dut_a: SPI mode 3, shifts out on SCLK fall, captures MOSI on SCLK rise
    logic [47:0] sl_bytes = 48'h0;
    logic [55:0] sl_tx = 56'h0;
    logic [55:0] sl_rx = 56'h0;
    logic        sl_miso = 1'b0;
    int          sl_falls = 0;

    assign ifa.spi_miso = sl_miso;
    assign ifb.spi_miso = 1'b0;

    always @(negedge ifa.spi_cs_n or negedge ifa.spi_sclk) begin
        if (ifa.spi_sclk === 1'b1) begin
            sl_tx    = {8'h00, sl_bytes};
            sl_falls = 0;
        end else if (ifa.spi_cs_n === 1'b0) begin
            sl_miso  = sl_tx[55];
            sl_tx    = {sl_tx[54:0], 1'b0};
            sl_falls = sl_falls + 1;
        end
    end

    always @(posedge ifa.spi_sclk) begin
        if (ifa.spi_cs_n === 1'b0) sl_rx = {sl_rx[54:0], ifa.spi_mosi};
    end

    // Reference model of the published word
    logic [15:0] exp_seq = 16'h0000;
    logic [15:0] mx = 16'h0000;
    logic [15:0] my = 16'h0000;
    logic [15:0] mz = 16'h0000;

`ifdef IMU_FILTER_EN
    function automatic logic [15:0] iir(input logic [15:0] f, input logic [15:0] raw);
        int d;
        d = int'($signed(raw)) - int'($signed(f));
        d = d >>> 2;
        return f + d[15:0];
    endfunction
`endif

    task automatic model_publish(input logic [47:0] b, input logic ovr, output logic [95:0] w);
        exp_seq = exp_seq + 16'd1;
`ifdef IMU_FILTER_EN
        mx = iir(mx, b[47:32]);
        my = iir(my, b[31:16]);
        mz = iir(mz, b[15:0]);
`else
        mx = b[47:32];
        my = b[31:16];
        mz = b[15:0];
`endif
        w = {exp_seq, 16'h0000, mz, mx, my, 15'h0000, ovr};
    endtask

    task automatic model_reset;
        exp_seq = 16'h0000;
        mx = 16'h0000;
        my = 16'h0000;
        mz = 16'h0000;
    endtask

    task automatic wait_a_cs(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ifa.spi_cs_n === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_b_cs(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ifb.spi_cs_n === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rst_b   = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifa.spi_sclk, ifa.spi_cs_n, ifa.spi_mosi, ifa.data_valid, ifa.busy} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_pins: got %b want 11000",
                     {ifa.spi_sclk, ifa.spi_cs_n, ifa.spi_mosi, ifa.data_valid, ifa.busy});
        end
        vectors++;
        if (ifa.data !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", ifa.data);
        end
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_wake;
        bit ok;
        bit saw_valid;
        bit saw_cs_low;
        saw_valid = 1'b0;
        wait_a_cs(1'b0, 50, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wake_start: cs_n got %b want 0", ifa.spi_cs_n); end
        for (int n = 0; n < 400 && ifa.spi_cs_n === 1'b0; n++) begin
            if (ifa.data_valid !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (ifa.spi_cs_n !== 1'b1 || sl_falls != 16) begin
            miscompares++;
            $display("FAIL wake_sclk_falls: got %0d want 16", sl_falls);
        end
        vectors++;
        if (sl_rx[15:0] !== 16'h6B00) begin
            miscompares++;
            $display("FAIL wake_mosi: got %h want 6b00", sl_rx[15:0]);
        end
        vectors++;
        if (ifa.busy !== 1'b1) begin miscompares++; $display("FAIL wake_gap_busy: got %b want 1", ifa.busy); end
        saw_cs_low = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ifa.spi_cs_n !== 1'b1) saw_cs_low = 1'b1;
            if (ifa.data_valid !== 1'b0) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_cs_low) begin miscompares++; $display("FAIL wake_gap_cs: got low want high for 8+ cycles"); end
        vectors++;
        if (ifa.busy !== 1'b0) begin miscompares++; $display("FAIL wake_idle_busy: got %b want 0", ifa.busy); end
        vectors++;
        if (saw_valid) begin miscompares++; $display("FAIL wake_valid: got 1 want 0"); end
    endtask

    task automatic run_read(input logic [47:0] bytes, output int pulse_cyc, output logic [95:0] word);
        bit ok;
        logic [95:0] exp_w;
        sl_bytes = bytes;
        wait_a_cs(1'b0, 2500, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL read_start: cs_n got %b want 0", ifa.spi_cs_n); end
        wait_a_cs(1'b1, 600, ok);
        vectors++;
        if (!ok || sl_falls != 56) begin
            miscompares++;
            $display("FAIL read_sclk_falls: got %0d want 56", sl_falls);
        end
        vectors++;
        if (sl_rx !== {8'hBB, 48'h0}) begin
            miscompares++;
            $display("FAIL read_mosi: got %h want bb000000000000", sl_rx);
        end
        vectors++;
        if (ifa.data_valid !== 1'b0) begin miscompares++; $display("FAIL read_valid_early: got 1 want 0"); end
        model_publish(bytes, 1'b0, exp_w);
        @(negedge clk);
        pulse_cyc = cyc;
        word = ifa.data;
        vectors++;
        if (ifa.data_valid !== 1'b1) begin miscompares++; $display("FAIL read_valid_pulse: got %b want 1", ifa.data_valid); end
        vectors++;
        if (ifa.data !== exp_w) begin
            miscompares++;
            $display("FAIL read_data: got %h want %h", ifa.data, exp_w);
        end
        @(negedge clk);
        vectors++;
        if (ifa.data_valid !== 1'b0 || ifa.data !== exp_w) begin
            miscompares++;
            $display("FAIL read_hold: valid %b data %h want 0 / %h", ifa.data_valid, ifa.data, exp_w);
        end
    endtask

    int          t1;
    logic [95:0] w1;

    task automatic test_read;
        run_read({8'h01, 8'h00, 8'hFF, 8'h80, 8'h40, 8'h00}, t1, w1);
    endtask

    task automatic test_back_to_back;
        int t2;
        int t3;
        logic [95:0] w;
        run_read(48'h7FFF_8000_1234, t2, w);
        vectors++;
        if (t2 - t1 != 2000) begin miscompares++; $display("FAIL period_1_2: got %0d want 2000", t2 - t1); end
        vectors++;
        if (w[95:80] !== 16'd2) begin miscompares++; $display("FAIL seq_2: got %0d want 2", w[95:80]); end
        run_read(48'hFFFF_0001_ABCD, t3, w);
        vectors++;
        if (t3 - t2 != 2000) begin miscompares++; $display("FAIL period_2_3: got %0d want 2000", t3 - t2); end
        vectors++;
        if (w[95:80] !== 16'd3) begin miscompares++; $display("FAIL seq_3: got %0d want 3", w[95:80]); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        sl_bytes = 48'h1111_2222_3333;
        wait_a_cs(1'b0, 2500, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_start: cs_n got %b want 0", ifa.spi_cs_n); end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sl_falls >= 20) break;
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ifa.spi_sclk, ifa.spi_cs_n, ifa.spi_mosi, ifa.data_valid, ifa.busy} !== 5'b11000
            || ifa.data !== 96'h0) begin
            miscompares++;
            $display("FAIL abort_pins: got %b data %h want 11000 data 0",
                     {ifa.spi_sclk, ifa.spi_cs_n, ifa.spi_mosi, ifa.data_valid, ifa.busy}, ifa.data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        wait_a_cs(1'b0, 20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_rewake: cs_n got %b want 0", ifa.spi_cs_n); end
        wait_a_cs(1'b1, 300, ok);
        vectors++;
        if (!ok || sl_falls != 16 || sl_rx[15:0] !== 16'h6B00) begin
            miscompares++;
            $display("FAIL abort_wake_xfer: got %0d bits %h want 16 bits 6b00", sl_falls, sl_rx[15:0]);
        end
    endtask

    task automatic test_step;
        int t;
        logic [95:0] w;
        logic [15:0] want_x [3];
`ifdef IMU_FILTER_EN
        want_x[0] = 16'h0100;
        want_x[1] = 16'h01C0;
        want_x[2] = 16'h0250;
`else
        want_x[0] = 16'h0400;
        want_x[1] = 16'h0400;
        want_x[2] = 16'h0400;
`endif
        for (int k = 0; k < 3; k++) begin
            run_read(48'h0400_0000_0000, t, w);
            vectors++;
            if (w[47:32] !== want_x[k] || w[95:80] !== 16'(k + 1)) begin
                miscompares++;
                $display("FAIL step_x_%0d: got x %h seq %0d want x %h seq %0d",
                         k, w[47:32], w[95:80], want_x[k], k + 1);
            end
        end
    endtask

    task automatic test_overrun;
        bit ok;
        int len;
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_b_cs(1'b0, 200, ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL ovr_start_%0d: cs_n got %b want 0", k, ifb.spi_cs_n); end
            len = 0;
            while (ifb.spi_cs_n === 1'b0 && len < 1000) begin
                len++;
                @(negedge clk);
            end
            vectors++;
            if (len != ((k == 0) ? 132 : 452)) begin
                miscompares++;
                $display("FAIL ovr_window_%0d: got %0d want %0d", k, len, (k == 0) ? 132 : 452);
            end
            if (k > 0) begin
                @(negedge clk);
                vectors++;
                if (ifb.data_valid !== 1'b1 || ifb.data !== {16'(k), 79'h0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL ovr_publish_%0d: valid %b data %h want 1 / %h",
                             k, ifb.data_valid, ifb.data, {16'(k), 79'h0, 1'b1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_step();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
